// File: rtl/arb_pkg.sv
// Shared types and vector helpers for the arbiter client port.
// Helpers take a fixed-width vector; callers size-cast to and from their own width.
package arb_pkg;

  localparam int MAX_LEN = 32;

  typedef enum logic {
    IDLE,
    OWN
  } state_e;

  typedef enum logic [1:0] {
    OH_ZERO,
    OH_ONE,
    OH_MULTI
  } oh_kind_e;

  function automatic oh_kind_e onehot_chk(input logic [MAX_LEN-1:0] vec);
    if (vec == '0) return OH_ZERO;
    if ((vec & (vec - MAX_LEN'(1))) == '0) return OH_ONE;
    return OH_MULTI;
  endfunction

  // Index of the lowest set bit; 0 for an all-zero vector.
  function automatic int oh2idx(input logic [MAX_LEN-1:0] vec);
    int idx;
    idx = 0;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

  // Rotate left by one within the low len bits; bit len-1 wraps to bit 0.
  function automatic logic [MAX_LEN-1:0] rotl1(input logic [MAX_LEN-1:0] vec, input int len);
    logic [MAX_LEN-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < len) r[(i + 1) % len] = vec[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_owner_mux.sv
// Combinational steering of the owning source onto the shared output stream,
// with ready routed back only to the owner.
module arb_owner_mux #(
  parameter int LENGTH = 4,
  parameter int DATA_W = 32
) (
  input  logic                      en,
  input  logic [$clog2(LENGTH)-1:0] owner,
  input  logic [LENGTH-1:0]         src_valid,
  input  logic [LENGTH-1:0]         src_last,
  input  logic [LENGTH*DATA_W-1:0]  src_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [DATA_W-1:0]         out_data,
  output logic [LENGTH-1:0]         src_ready
);

  always_comb begin
    // NOTE: every output gets a default before the branch, so no path infers a latch.
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    src_ready = '0;
    if (en) begin
      out_valid        = src_valid[owner];
      out_last         = src_last[owner];
      out_data         = src_data[int'(owner)*DATA_W +: DATA_W];
      src_ready[owner] = out_ready;
    end
  end

endmodule

// File: rtl/arb_client_port.sv
// Client side of an external arbiter: raises requests, locks onto the granted
// source for a whole packet, and hands back a rotated round-robin priority.
module arb_client_port
  import arb_pkg::*;
#(
  parameter int LENGTH  = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LENGTH-1:0]         src_valid,
  input  logic [LENGTH-1:0]         src_last,
  input  logic [LENGTH*DATA_W-1:0]  src_data,
  output logic [LENGTH-1:0]         src_ready,
  output logic [LENGTH-1:0]         req,
  input  logic [LENGTH-1:0]         gnt,
  output logic [LENGTH-1:0]         prio,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [DATA_W-1:0]         out_data,
  input  logic                      out_ready,
  output logic [$clog2(LENGTH)-1:0] out_src,
  output logic                      gnt_err,
  output logic                      tmo_err
);

  localparam int IW = $clog2(LENGTH);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state;
  logic [IW-1:0]     owner;
  logic [LENGTH-1:0] prio_q;
  logic [CW-1:0]     stall_cnt;

  oh_kind_e          gnt_kind;
  logic              gnt_legal;
  logic              tmo_hit;
  logic              mux_en;
  logic              beat;
  logic [LENGTH-1:0] owner_oh;
  logic [LENGTH-1:0] next_prio;

  assign gnt_kind  = onehot_chk(MAX_LEN'(gnt));
  assign gnt_legal = (gnt_kind == OH_ONE) && (|(gnt & src_valid));
  assign tmo_hit   = (TIMEOUT != 0) && (state == OWN) && (stall_cnt == CW'(TIMEOUT));
  // The timeout cycle is masked so an abandoned packet cannot sneak out a beat.
  assign mux_en    = (state == OWN) && !tmo_hit;
  assign beat      = out_valid & out_ready;
  assign owner_oh  = LENGTH'(1) << owner;
  assign next_prio = LENGTH'(rotl1(MAX_LEN'(owner_oh), LENGTH));

  assign req     = (state == IDLE && !rst) ? src_valid : '0;
  assign prio    = rst ? '0 : prio_q;
  assign out_src = owner;

  arb_owner_mux #(
    .LENGTH (LENGTH),
    .DATA_W (DATA_W)
  ) u_mux (
    .en        (mux_en),
    .owner     (owner),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_data  (src_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .src_ready (src_ready)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= '0;
      prio_q    <= LENGTH'(1);
      stall_cnt <= '0;
      gnt_err   <= 1'b0;
      tmo_err   <= 1'b0;
    end else begin
      gnt_err <= 1'b0;
      tmo_err <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (gnt_legal) begin
            owner <= IW'(oh2idx(MAX_LEN'(gnt)));
            state <= OWN;
          end else if (gnt_kind != OH_ZERO) begin
            gnt_err <= 1'b1;
          end
        end
        OWN: begin
          if (tmo_hit) begin
            tmo_err   <= 1'b1;
            state     <= IDLE;
            prio_q    <= next_prio;
            stall_cnt <= '0;
          end else if (beat) begin
            stall_cnt <= '0;
            if (out_last) begin
              state  <= IDLE;
              prio_q <= next_prio;
            end
          end else if (TIMEOUT != 0) begin
            stall_cnt <= stall_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_client_port.sv
// Self-checking bench for arb_client_port: directed table, corner sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_arb_client_port;

  localparam int LEN = 4;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [LEN-1:0]    src_valid, src_last, src_ready, req, gnt, prio;
  logic [LEN*DW-1:0] src_data;
  logic              out_valid, out_last, out_ready, gnt_err, tmo_err;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_src;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arb_client_port #(
    .LENGTH  (LEN),
    .DATA_W  (DW),
    .TIMEOUT (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_valid (src_valid),
    .src_last  (src_last),
    .src_data  (src_data),
    .src_ready (src_ready),
    .req       (req),
    .gnt       (gnt),
    .prio      (prio),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_src   (out_src),
    .gnt_err   (gnt_err),
    .tmo_err   (tmo_err)
  );

  typedef struct {
    logic [3:0] sv, sl, gnt;
    logic       ordy;
    logic [3:0] req, srdy, prio;
    logic       ov, ol;
    logic [1:0] osrc;
    logic       gerr, terr;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] sdat [4];

  // behavioural model state
  bit m_own;
  int m_owner, m_prio, m_stall;
  bit m_gerr, m_terr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] ctl();
    return {req, src_ready, prio, out_valid, out_last, out_src, gnt_err, tmo_err};
  endfunction

  function automatic logic [17:0] mk(input logic [3:0] r, input logic [3:0] s, input logic [3:0] p,
                                     input logic v, input logic l, input logic [1:0] o,
                                     input logic ge, input logic te);
    return {r, s, p, v, l, o, ge, te};
  endfunction

  function automatic logic [49:0] snapshot();
    return {ctl(), out_data};
  endfunction

  function automatic logic [49:0] model_expect();
    logic [3:0]  r, s, p;
    logic        v, l;
    logic [31:0] d;
    bit          live;
    r = '0; s = '0; v = 1'b0; l = 1'b0; d = '0;
    p = 4'(1 << m_prio);
    live = m_own && (m_stall != TMO);
    if (!m_own) r = src_valid;
    if (live) begin
      v = src_valid[m_owner];
      l = src_last[m_owner];
      d = src_data[m_owner*DW +: DW];
      s[m_owner] = out_ready;
    end
    return {r, s, p, v, l, 2'(m_owner), m_gerr, m_terr, d};
  endfunction

  task automatic model_step();
    int hits, idx;
    m_gerr = 1'b0;
    m_terr = 1'b0;
    if (!m_own) begin
      if (gnt != 0) begin
        hits = $countones(gnt);
        idx  = 0;
        for (int k = 0; k < LEN; k++) if (gnt[k]) idx = k;
        if (hits == 1 && (gnt & src_valid) != 0) begin
          m_own = 1'b1; m_owner = idx; m_stall = 0;
        end else begin
          m_gerr = 1'b1;
        end
      end
    end else if (m_stall == TMO) begin
      m_terr = 1'b1; m_own = 1'b0; m_prio = (m_owner + 1) % LEN;
    end else if (src_valid[m_owner] && out_ready) begin
      m_stall = 0;
      if (src_last[m_owner]) begin
        m_own = 1'b0; m_prio = (m_owner + 1) % LEN;
      end
    end else begin
      m_stall++;
    end
  endtask

  function automatic logic [3:0] pick_gnt(input logic [3:0] v);
    logic [3:0] g;
    int r, k;
    g = '0;
    r = $urandom_range(0, 9);
    if (r >= 5 && r <= 7 && v != 0) begin
      k = $urandom_range(0, 3);
      for (int n = 0; n < 4 && !v[k]; n++) k = (k + 1) % 4;
      g[k] = 1'b1;
    end else if (r == 8) begin
      g = 4'($urandom);
    end else if (r == 9) begin
      g[$urandom_range(0, 3)] = 1'b1;
    end
    return g;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    sdat[0] = 32'hC0DE_0000; sdat[1] = 32'hC0DE_1111;
    sdat[2] = 32'hC0DE_2222; sdat[3] = 32'hC0DE_3333;
    //            sv       sl       gnt      rdy  req      srdy     prio     ov  ol  src gerr terr
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 1, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0, 0};
    tbl[1]  = '{4'b0001, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0001, 1, 0, 0, 0, 0};
    tbl[2]  = '{4'b0001, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0001, 1, 0, 0, 0, 0};
    tbl[3]  = '{4'b0001, 4'b0001, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0001, 1, 1, 0, 0, 0};
    tbl[4]  = '{4'b0001, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0010, 0, 0, 0, 0, 0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0010, 0, 0, 0, 0, 0};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0100, 1, 4'b1111, 4'b0000, 4'b0010, 0, 0, 0, 0, 0};
    tbl[7]  = '{4'b1111, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0100, 4'b0010, 1, 0, 2, 0, 0};
    tbl[8]  = '{4'b1111, 4'b0100, 4'b1000, 1, 4'b0000, 4'b0100, 4'b0010, 1, 1, 2, 0, 0};
    tbl[9]  = '{4'b1111, 4'b0000, 4'b1000, 1, 4'b1111, 4'b0000, 4'b1000, 0, 0, 2, 0, 0};
    tbl[10] = '{4'b1111, 4'b1000, 4'b0000, 1, 4'b0000, 4'b1000, 4'b1000, 1, 1, 3, 0, 0};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 3, 0, 0};
    tbl[12] = '{4'b1111, 4'b0000, 4'b0110, 1, 4'b1111, 4'b0000, 4'b0001, 0, 0, 3, 0, 0};
    tbl[13] = '{4'b0001, 4'b0000, 4'b0010, 1, 4'b0001, 4'b0000, 4'b0001, 0, 0, 3, 1, 0};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 3, 1, 0};
    tbl[15] = '{4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 0, 0, 3, 0, 0};

    // reset: every output low, even with all sources valid
    rst = 1'b1; src_valid = 4'b1111; src_last = '0; gnt = '0; out_ready = 1'b1;
    src_data = {sdat[3], sdat[2], sdat[1], sdat[0]};
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'(snapshot()), 64'(0));
    rst = 1'b0;

    // directed table: single-source packet, rotation with wrap, illegal grants
    for (int i = 0; i < 16; i++) begin
      src_valid = tbl[i].sv; src_last = tbl[i].sl; gnt = tbl[i].gnt; out_ready = tbl[i].ordy;
      @(negedge clk);
      check($sformatf("row %0d ctl", i), 64'(ctl()),
            64'(mk(tbl[i].req, tbl[i].srdy, tbl[i].prio, tbl[i].ov, tbl[i].ol,
                   tbl[i].osrc, tbl[i].gerr, tbl[i].terr)));
      if (tbl[i].ov) check($sformatf("row %0d data", i), 64'(out_data), 64'(sdat[tbl[i].osrc]));
      tick();
    end

    // owner 1 drops valid mid-packet: ownership held, others never readied
    src_valid = 4'b0010; src_last = '0; gnt = 4'b0010; out_ready = 1'b1;
    @(negedge clk); check("hold grant", 64'(ctl()), 64'(mk(4'b0010, 4'b0000, 4'b0001, 0, 0, 3, 0, 0)));
    tick();
    gnt = '0;
    @(negedge clk); check("hold beat", 64'(ctl()), 64'(mk(4'b0000, 4'b0010, 4'b0001, 1, 0, 1, 0, 0)));
    tick();
    src_valid = 4'b1101;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("hold gap %0d", k), 64'(ctl()), 64'(mk(4'b0000, 4'b0010, 4'b0001, 0, 0, 1, 0, 0)));
      tick();
    end
    src_valid = 4'b0010; src_last = 4'b0010;
    @(negedge clk); check("hold last", 64'(ctl()), 64'(mk(4'b0000, 4'b0010, 4'b0001, 1, 1, 1, 0, 0)));
    tick();
    src_valid = '0; src_last = '0;
    @(negedge clk); check("hold release", 64'(ctl()), 64'(mk(4'b0000, 4'b0000, 4'b0100, 0, 0, 1, 0, 0)));
    tick();

    // reset in the middle of owner 0's second beat
    src_valid = 4'b0001; gnt = 4'b0001;
    @(negedge clk); check("rst grant", 64'(ctl()), 64'(mk(4'b0001, 4'b0000, 4'b0100, 0, 0, 1, 0, 0)));
    tick();
    gnt = '0;
    @(negedge clk); check("rst beat1", 64'(ctl()), 64'(mk(4'b0000, 4'b0001, 4'b0100, 1, 0, 0, 0, 0)));
    tick();
    #2 rst = 1'b1;
    #1 check("rst async", 64'(snapshot()), 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("rst held", 64'(snapshot()), 64'(0));
    rst = 1'b0;
    tick();
    @(negedge clk); check("rst after", 64'(ctl()), 64'(mk(4'b0001, 4'b0000, 4'b0001, 0, 0, 0, 0, 0)));
    tick();

    // owner 3 stalls with out_ready low until forced release
    src_valid = 4'b1000; gnt = 4'b1000; out_ready = 1'b0;
    @(negedge clk); check("tmo grant", 64'(ctl()), 64'(mk(4'b1000, 4'b0000, 4'b0001, 0, 0, 0, 0, 0)));
    tick();
    gnt = '0;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      check($sformatf("tmo stall %0d", k), 64'(ctl()), 64'(mk(4'b0000, 4'b0000, 4'b0001, 1, 0, 3, 0, 0)));
      tick();
    end
    @(negedge clk); check("tmo hit", 64'(ctl()), 64'(mk(4'b0000, 4'b0000, 4'b0001, 0, 0, 3, 0, 0)));
    tick();
    @(negedge clk); check("tmo pulse", 64'(ctl()), 64'(mk(4'b1000, 4'b0000, 4'b0001, 0, 0, 3, 0, 1)));
    tick();
    src_valid = '0;
    @(negedge clk); check("tmo clear", 64'(ctl()), 64'(mk(4'b0000, 4'b0000, 4'b0001, 0, 0, 3, 0, 0)));
    tick();

    // randomized traffic against the model
    rst = 1'b1; src_valid = '0; src_last = '0; gnt = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    m_own = 1'b0; m_owner = 0; m_prio = 0; m_stall = 0; m_gerr = 1'b0; m_terr = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      src_valid = 4'($urandom | $urandom);
      src_last  = 4'($urandom & $urandom);
      out_ready = ((c % 250) < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
      for (int j = 0; j < LEN; j++) src_data[j*DW +: DW] = $urandom;
      gnt = pick_gnt(src_valid);
      @(negedge clk);
      check($sformatf("rand cyc %0d", c), 64'(snapshot()), 64'(model_expect()));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
